logic_gate_unit: RTL and testbench
==================================

# logic_gate_unit

Parametrised, registered successor to the single-bit 2-input AND gate. Applies one of six bitwise logic functions, selected per transaction, across `NUM_IN` operands of `WIDTH` bits each. Results pass through a 2-entry output buffer with valid/ready handshakes on both sides. It sits between a stimulus or data source and any downstream consumer that can apply backpressure.

## Interface

**Parameters**
- `WIDTH`, default 8: bit width of each operand and of the result; at least 1.
- `NUM_IN`, default 2: number of operands reduced per transaction; at least 2.

**Ports**
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `in_valid`, input, 1: an input transaction is presented.
- `in_ready`, output, 1: the block accepts the transaction this cycle.
- `op`, input, 3: function select, using `op_e` from the package.
- `a`, input, `NUM_IN`×`WIDTH` (packed `[NUM_IN-1:0][WIDTH-1:0]`): the operands.
- `out_valid`, output, 1: a result is available.
- `out_ready`, input, 1: the consumer takes the result this cycle.
- `y`, output, `WIDTH`: the result.
- `y_zero`, output, 1: `y` is all zeros.
- `y_ones`, output, 1: `y` is all ones.
- `op_err`, output, 1: the current result came from an illegal `op`.

## Operation

**Functions, with bit i of `y` computed over bit i of every operand:**
- `OP_AND` = 0: AND
- `OP_OR` = 1: OR
- `OP_XOR` = 2: XOR, i.e. odd parity
- `OP_NAND` = 3: NOT AND
- `OP_NOR` = 4: NOT OR
- `OP_XNOR` = 5: NOT XOR

**Illegal op (6 or 7):**
- `y` = 0 and `op_err` = 1 for that entry.
- `y_zero` = 1 for that entry.

**Accept and deliver:**
- A transaction is accepted when `in_valid && in_ready` at a rising edge.
- The result and its flags are computed combinationally and written into the buffer at that edge.
- A result is delivered when `out_valid && out_ready`.

**Buffer:**
- 2 entries, FIFO order.
- An occupancy counter of 0..2 drives `in_ready = (count != 2)` and `out_valid = (count != 0)`.
- `y`, `y_zero`, `y_ones` and `op_err` always show the head entry.

**Boundary conditions:**
- count 0, push only: count becomes 1; the result appears the next cycle.
- count 1, push and pop in the same cycle: count stays 1; the head is replaced by the new result.
- count 2: `in_ready` = 0 and `in_valid` is ignored. A pop makes count 1 and raises `in_ready` the following cycle. `in_ready` has no combinational path from `out_ready`.
- Pop at count 0: impossible, because `out_valid` = 0.
- Producer rules: `op` and `a` are sampled only on acceptance. The producer must hold `in_valid`, `op` and `a` stable until accepted.
- Consumer view: while `out_valid` = 1 and `out_ready` = 0, `y` and the flags hold stable.

**Reset:**
- While `rst_n` = 0 at a rising edge: count = 0 and all buffered data is dropped, including in-flight results.

**Reset values:**
- `out_valid` = 0
- `in_ready` = 1, from the first edge after reset
- `y` = 0
- `y_zero` = 1
- `y_ones` = 0
- `op_err` = 0

## Timing

- Latency: 1 cycle. Accepted at edge N, visible on `y` after edge N, i.e. `out_valid` is high in cycle N+1.
- Throughput: 1 transaction per cycle while `out_ready` = 1 continuously.
- No combinational path from any input to any output. Every output is a function of registers only.
- With `out_ready` held 0: exactly 2 transactions are accepted, then `in_ready` drops.

## Structure

**Package `logic_gate_pkg`:**
- `op_e`, a 3-bit enum containing `OP_AND` … `OP_XNOR`.
- Constant `OP_LAST` = `OP_XNOR`, used for the illegal-op check.

**Sub-module `logic_reduce`:**
- Combinational, parameters `WIDTH` and `NUM_IN`.
- Inputs `op` and `a`.
- Outputs `y` and `err`.
- It is instantiated once.

**Top level:** holds the 2-entry storage, read/write pointers, the counter and the flag generation.

## Test plan

- **Truth table** (`WIDTH`=1, `NUM_IN`=2, `out_ready`=1): cover all 4 operand combinations × 6 ops. Required: `OP_AND` gives `y` = 0,0,0,1 for `ab` = 00,01,10,11; every other op matches its truth table; each result appears 1 cycle after acceptance.
- **Multi-operand** (`WIDTH`=8, `NUM_IN`=3, `a` = {8'hF0, 8'hCC, 8'hAA}):
  - `OP_AND` → 8'h80
  - `OP_OR` → 8'hFE
  - `OP_XOR` → 8'h96
  - `OP_NOR` → 8'h01
- **Flags:** all operands 8'hFF with `OP_AND` → `y_ones` = 1, `y_zero` = 0. `op` = 6 → `y` = 0, `op_err` = 1, `y_zero` = 1.
- **Backpressure:** hold `out_ready` = 0 and stream 4 transactions. Required: exactly 2 are accepted, `in_ready` = 0 from the cycle after the second acceptance, and `y` is stable. Then raise `out_ready`. Required: the results drain in order, with the remaining 2 transactions accepted afterward.
- **Simultaneous push and pop** at count 1 for 10 cycles. Required: count stays 1, `in_ready` stays 1, and no results are lost or duplicated (bench scoreboard).
- **Reset mid-operation:** with the buffer full, assert `rst_n` = 0 for 1 cycle. Required: on the next cycle `out_valid` = 0, `in_ready` = 1, `y` = 0, and no stale results are ever delivered afterward.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// Shared types and constants for the logic_gate_unit block.
//   op_e     : function select encoding (values 6 and 7 are illegal)
//   OP_LAST  : highest legal op, used for the illegal-op check
//   BUF_DEPTH: number of result buffer entries
package logic_gate_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5
  } op_e;

  localparam op_e OP_LAST = OP_XNOR;

  localparam int unsigned BUF_DEPTH = 2;

endpackage

// File: rtl/logic_reduce.sv
// Combinational bitwise reduction of NUM_IN operands of WIDTH bits.
// Ports:
//   op  : function select (op_e encoding, 6/7 illegal)
//   a   : packed operands, a[i] is operand i
//   y   : result, bit j computed over bit j of every operand; 0 for illegal op
//   err : op is illegal
module logic_reduce
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2
) (
  input  logic [2:0]                   op,
  input  logic [NUM_IN-1:0][WIDTH-1:0] a,
  output logic [WIDTH-1:0]             y,
  output logic                         err
);

  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] or_r;
  logic [WIDTH-1:0] xor_r;

  always_comb begin
    and_r = '1;
    or_r  = '0;
    xor_r = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      and_r = and_r & a[i];
      or_r  = or_r | a[i];
      xor_r = xor_r ^ a[i];
    end
  end

  always_comb begin
    err = (op > 3'(OP_LAST));
    y   = '0;
    case (op)
      3'(OP_AND):  y = and_r;
      3'(OP_OR):   y = or_r;
      3'(OP_XOR):  y = xor_r;
      3'(OP_NAND): y = ~and_r;
      3'(OP_NOR):  y = ~or_r;
      3'(OP_XNOR): y = ~xor_r;
      default:     y = '0;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered multi-operand bitwise logic unit with a 2-entry output FIFO.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : input handshake; op and a sampled on acceptance
//   op, a                : function select and packed operands
//   out_valid / out_ready: output handshake
//   y, y_zero, y_ones    : head-entry result and its all-zero / all-one flags
//   op_err               : head entry came from an illegal op
// All outputs are driven from registers only; in_ready depends on the count,
// never on out_ready.
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   op,
  input  logic [NUM_IN-1:0][WIDTH-1:0] a,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             y,
  output logic                         y_zero,
  output logic                         y_ones,
  output logic                         op_err
);

  logic [WIDTH-1:0] res_y;
  logic             res_err;

  logic_reduce #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_reduce (
    .op  (op),
    .a   (a),
    .y   (res_y),
    .err (res_err)
  );

  // Buffer storage, one slot per entry.
  logic [BUF_DEPTH-1:0][WIDTH-1:0] y_q, y_d;
  logic [BUF_DEPTH-1:0]            zero_q, zero_d;
  logic [BUF_DEPTH-1:0]            ones_q, ones_d;
  logic [BUF_DEPTH-1:0]            err_q, err_d;
  logic                            wr_ptr_q, wr_ptr_d;
  logic                            rd_ptr_q, rd_ptr_d;
  logic [1:0]                      count_q, count_d;

  logic push;
  logic pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    y_d    = y_q;
    zero_d = zero_q;
    ones_d = ones_q;
    err_d  = err_q;
    if (push) begin
      y_d[wr_ptr_q]    = res_y;
      zero_d[wr_ptr_q] = (res_y == '0);
      ones_d[wr_ptr_q] = &res_y;
      err_d[wr_ptr_q]  = res_err;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Reset also clears storage so the head entry reads as an all-zero result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q      <= '0;
      zero_q   <= '1;
      ones_q   <= '0;
      err_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      y_q      <= y_d;
      zero_q   <= zero_d;
      ones_q   <= ones_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign y      = y_q[rd_ptr_q];
  assign y_zero = zero_q[rd_ptr_q];
  assign y_ones = ones_q[rd_ptr_q];
  assign op_err = err_q[rd_ptr_q];

endmodule

// File: tb/tb_logic_gate_unit.sv
module tb_logic_gate_unit;
  import logic_gate_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 1-bit, 2-operand instance for the truth table.
  logic            in_valid1, in_ready1, out_valid1, out_ready1;
  logic [2:0]      op1;
  logic [1:0][0:0] a1;
  logic [0:0]      y1;
  logic            y_zero1, y_ones1, op_err1;

  // 8-bit, 3-operand instance for everything else.
  logic            in_valid3, in_ready3, out_valid3, out_ready3;
  logic [2:0]      op3;
  logic [2:0][7:0] a3;
  logic [7:0]      y3;
  logic            y_zero3, y_ones3, op_err3;

  logic_gate_unit #(.WIDTH(1), .NUM_IN(2)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .op        (op1),
    .a         (a1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .y         (y1),
    .y_zero    (y_zero1),
    .y_ones    (y_ones1),
    .op_err    (op_err1)
  );

  logic_gate_unit #(.WIDTH(8), .NUM_IN(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .op        (op3),
    .a         (a3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .y         (y3),
    .y_zero    (y_zero3),
    .y_ones    (y_ones3),
    .op_err    (op_err3)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Hand-computed results for a = {F0, CC, AA}, indexed by op.
  logic [7:0] exp6 [6];
  // Truth tables, bit index = {a[1], a[0]}.
  logic [3:0] tt [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid1 = 1'b0; op1 = 3'd0; a1 = '0; out_ready1 = 1'b1;
    in_valid3 = 1'b0; op3 = 3'd0; a3 = '0; out_ready3 = 1'b0;
    step();
    step();
    checks++;
    if ({out_valid3, in_ready3, y3, y_zero3, y_ones3, op_err3} !== {1'b0, 1'b1, 8'h00, 3'b100}) begin
      errors++;
      $display("FAIL reset_state got v=%b r=%b y=%h z=%b o=%b e=%b want v=0 r=1 y=00 z=1 o=0 e=0",
               out_valid3, in_ready3, y3, y_zero3, y_ones3, op_err3);
    end
    checks++;
    if ({out_valid1, in_ready1, y1, y_zero1} !== 4'b0101) begin
      errors++;
      $display("FAIL reset_state_w1 got v=%b r=%b y=%b z=%b want v=0 r=1 y=0 z=1",
               out_valid1, in_ready1, y1, y_zero1);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_truth_table();
    logic [3:0] row;
    for (int o = 0; o < 6; o++) begin
      for (int ab = 0; ab < 4; ab++) begin
        in_valid1 = 1'b1;
        op1 = 3'(o);
        a1 = 2'(ab);
        row = tt[o];
        step();
        checks++;
        if ({out_valid1, y1} !== {1'b1, row[ab]}) begin
          errors++;
          $display("FAIL truth_op%0d_ab%0d got v=%b y=%b want v=1 y=%b", o, ab, out_valid1, y1,
                   row[ab]);
        end
      end
    end
    in_valid1 = 1'b0;
    step();
    step();
    checks++;
    if (out_valid1 !== 1'b0) begin
      errors++;
      $display("FAIL truth_drain got out_valid=%b want 0", out_valid1);
    end
  endtask

  task automatic test_multi_operand();
    out_ready3 = 1'b1;
    a3 = {8'hF0, 8'hCC, 8'hAA};
    for (int o = 0; o < 6; o++) begin
      in_valid3 = 1'b1;
      op3 = 3'(o);
      step();
      checks++;
      if ({out_valid3, y3, op_err3} !== {1'b1, exp6[o], 1'b0}) begin
        errors++;
        $display("FAIL multi_op%0d got v=%b y=%h err=%b want v=1 y=%h err=0", o, out_valid3, y3,
                 op_err3, exp6[o]);
      end
    end
    in_valid3 = 1'b0;
    step();
  endtask

  task automatic test_flags();
    out_ready3 = 1'b1;
    in_valid3 = 1'b1;
    op3 = OP_AND;
    a3 = {8'hFF, 8'hFF, 8'hFF};
    step();
    checks++;
    if ({y3, y_ones3, y_zero3, op_err3} !== {8'hFF, 3'b100}) begin
      errors++;
      $display("FAIL flags_ones got y=%h o=%b z=%b e=%b want y=ff o=1 z=0 e=0", y3, y_ones3,
               y_zero3, op_err3);
    end
    op3 = 3'd6;
    step();
    checks++;
    if ({out_valid3, y3, y_ones3, y_zero3, op_err3} !== {1'b1, 8'h00, 3'b011}) begin
      errors++;
      $display("FAIL flags_op6 got v=%b y=%h o=%b z=%b e=%b want v=1 y=00 o=0 z=1 e=1",
               out_valid3, y3, y_ones3, y_zero3, op_err3);
    end
    op3 = 3'd7;
    step();
    checks++;
    if ({y3, y_zero3, op_err3} !== {8'h00, 2'b11}) begin
      errors++;
      $display("FAIL flags_op7 got y=%h z=%b e=%b want y=00 z=1 e=1", y3, y_zero3, op_err3);
    end
    in_valid3 = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    int  si = 0;
    int  ri = 0;
    logic acc;
    a3 = {8'hF0, 8'hCC, 8'hAA};
    out_ready3 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid3 = (si < 4);
      op3 = 3'(si);
      if (c >= 2) begin
        checks++;
        if ({in_ready3, out_valid3, y3} !== {2'b01, 8'h80}) begin
          errors++;
          $display("FAIL bp_hold_c%0d got r=%b v=%b y=%h want r=0 v=1 y=80", c, in_ready3,
                   out_valid3, y3);
        end
      end
      acc = in_valid3 && in_ready3;
      step();
      if (acc) si++;
    end
    checks++;
    if (si != 2) begin
      errors++;
      $display("FAIL bp_accepted got %0d want 2", si);
    end
    out_ready3 = 1'b1;
    checks++;
    if (in_ready3 !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_comb_ready got in_ready=%b want 0", in_ready3);
    end
    for (int c = 0; c < 20 && ri < 4; c++) begin
      in_valid3 = (si < 4);
      op3 = 3'(si);
      if (out_valid3) begin
        checks++;
        if (y3 !== exp6[ri]) begin
          errors++;
          $display("FAIL bp_drain%0d got y=%h want %h", ri, y3, exp6[ri]);
        end
        ri++;
      end
      acc = in_valid3 && in_ready3;
      step();
      if (acc) si++;
    end
    in_valid3 = 1'b0;
    checks++;
    if (ri != 4 || si != 4 || out_valid3 !== 1'b0) begin
      errors++;
      $display("FAIL bp_complete got delivered=%0d accepted=%0d v=%b want 4 4 0", ri, si,
               out_valid3);
    end
  endtask

  task automatic test_back_to_back();
    a3 = {8'hF0, 8'hCC, 8'hAA};
    out_ready3 = 1'b0;
    in_valid3 = 1'b1;
    op3 = 3'd0;
    step();
    out_ready3 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      op3 = 3'(k % 6);
      checks++;
      if ({in_ready3, out_valid3, y3} !== {2'b11, exp6[(k - 1) % 6]}) begin
        errors++;
        $display("FAIL b2b_k%0d got r=%b v=%b y=%h want r=1 v=1 y=%h", k, in_ready3, out_valid3,
                 y3, exp6[(k - 1) % 6]);
      end
      step();
    end
    in_valid3 = 1'b0;
    checks++;
    if ({out_valid3, y3} !== {1'b1, exp6[4]}) begin
      errors++;
      $display("FAIL b2b_last got v=%b y=%h want v=1 y=%h", out_valid3, y3, exp6[4]);
    end
    step();
    checks++;
    if (out_valid3 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty got out_valid=%b want 0", out_valid3);
    end
  endtask

  task automatic test_reset_mid();
    a3 = {8'hF0, 8'hCC, 8'hAA};
    out_ready3 = 1'b0;
    in_valid3 = 1'b1;
    op3 = OP_OR;
    step();
    op3 = OP_XOR;
    step();
    in_valid3 = 1'b0;
    checks++;
    if ({in_ready3, out_valid3, y3} !== {2'b01, 8'hFE}) begin
      errors++;
      $display("FAIL rst_mid_full got r=%b v=%b y=%h want r=0 v=1 y=fe", in_ready3, out_valid3,
               y3);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({out_valid3, in_ready3, y3, y_zero3, op_err3} !== {2'b01, 8'h00, 2'b10}) begin
      errors++;
      $display("FAIL rst_mid_state got v=%b r=%b y=%h z=%b e=%b want v=0 r=1 y=00 z=1 e=0",
               out_valid3, in_ready3, y3, y_zero3, op_err3);
    end
    out_ready3 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (out_valid3 !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_stale_c%0d got out_valid=%b want 0", c, out_valid3);
      end
    end
    in_valid3 = 1'b1;
    op3 = OP_NAND;
    step();
    in_valid3 = 1'b0;
    checks++;
    if ({out_valid3, y3} !== {1'b1, 8'h7F}) begin
      errors++;
      $display("FAIL rst_mid_resume got v=%b y=%h want v=1 y=7f", out_valid3, y3);
    end
    step();
  endtask

  initial begin
    exp6[0] = 8'h80; exp6[1] = 8'hFE; exp6[2] = 8'h96;
    exp6[3] = 8'h7F; exp6[4] = 8'h01; exp6[5] = 8'h69;
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110;
    tt[3] = 4'b0111; tt[4] = 4'b0001; tt[5] = 4'b1001;

    test_reset();
    test_truth_table();
    test_multi_operand();
    test_flags();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
